control_store_loader: RTL

// - Writer side of the microcode control store: loads microinstruction words into a writable control store (WCS) at boot or debug time.
// - Accepts a byte stream on a valid/ready handshake and packs each group of bytes little-endian into one DATA_W-bit word.
// - Drives sequential single-cycle WCS writes starting at a programmable base address.
// - Sits between the debug/boot byte source and the WCS write port; the sequencer keeps reading the WCS when busy is low.

---
 rtl/control_store_loader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_store_loader.sv
// control_store_loader
//   Writer side of the microcode writable control store (WCS). Receives a
//   byte stream over a valid/ready handshake and packs every BYTES bytes
//   (little-endian) into one DATA_W-bit microinstruction. Each word is
//   written to the WCS with a single-cycle strobe, at consecutive addresses
//   starting from a base captured on start. The address wraps modulo
//   2**ADDR_W.
//
// Optional feature (macro CS_LOADER_CHECKSUM_EN):
//   An 8-bit running sum of every data byte is kept. After the last write,
//   one extra byte is accepted and compared with that sum. A match finishes
//   the load normally; a mismatch raises error.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous reset, active low
//   start_i      one-cycle load request, only looked at while idle
//   base_addr_i  first WCS address, captured on start
//   count_i      words to load (0..2**ADDR_W), captured on start
//   in_data_i    stream byte
//   in_valid_i   stream byte valid
//   in_ready_o   loader accepts a byte this cycle
//   wr_en_o      WCS write strobe, one cycle per word
//   wr_addr_o    WCS write address
//   wr_data_o    WCS write data
//   busy_o       load in progress
//   done_o       one-cycle pulse on successful completion
//   error_o      sticky fault flag, cleared by the next accepted start
module control_store_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 23
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int BYTES = (DATA_W + 7) / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  // Largest legal word count is the full store depth.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  // Bits of the final byte that lie above the word's MSB and must be zero.
  localparam logic [7:0] TOP_MASK = 8'(8'hFF << (DATA_W - 8 * (BYTES - 1)));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef CS_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W:0]   cnt_q;
  logic [IDX_W-1:0]  idx_q;
`ifdef CS_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic              byte_hs;
  logic [DATA_W-1:0] wr_data_d;

  // Any set bit above DATA_W-1 in the last byte of a word is a malformed word.
  function automatic logic top_bits_bad(input logic [7:0] b);
    return |(b & TOP_MASK);
  endfunction

  // Place a byte into lane idx of the word; bits shifted past DATA_W drop off.
  function automatic logic [DATA_W-1:0] insert_byte(input logic [DATA_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [7:0]        b);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;
    mask = DATA_W'(8'hFF) << {idx, 3'b000};
    ins  = DATA_W'(b) << {idx, 3'b000};
    return (word & ~mask) | (ins & mask);
  endfunction

  // Handshake detect and next packed word.
  always_comb begin
    byte_hs   = in_valid_i & in_ready_q;
    wr_data_d = insert_byte(wr_data_q, idx_q, in_data_i);
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
`ifdef CS_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            error_q   <= 1'b0;
            wr_addr_q <= base_addr_i;
            cnt_q     <= count_i;
            idx_q     <= '0;
`ifdef CS_LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
            if (count_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (count_i > MAX_CNT) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end else begin
              state_q    <= S_RECV;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (byte_hs) begin
            wr_data_q <= wr_data_d;
`ifdef CS_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + in_data_i;
`endif
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              in_ready_q <= 1'b0;
              if (top_bits_bad(in_data_i)) begin
                state_q <= S_ERR;
                error_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_WRITE;
                wr_en_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          // Address and data were stable for the strobe; advance afterwards.
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
          cnt_q     <= cnt_q - (ADDR_W + 1)'(1);
          if (cnt_q == (ADDR_W + 1)'(1)) begin
`ifdef CS_LOADER_CHECKSUM_EN
            state_q    <= S_CSUM;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
`endif
          end else begin
            state_q    <= S_RECV;
            in_ready_q <= 1'b1;
          end
        end
`ifdef CS_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (byte_hs) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data_i == sum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = in_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule
